// File: rtl/output_neuron_trainer.sv
// Perceptron trainer for the output neuron: holds N_IN signed weights and, on a
// misclassified sample, walks them one per cycle adding +/-LR with saturation.
module output_neuron_trainer #(
    parameter int N_IN    = 5,
    parameter int W_WIDTH = 10,
    parameter int LR      = 8,
    parameter int INIT_W  = 0
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      load_en,
    input  logic [2:0]                load_idx,
    input  logic [W_WIDTH-1:0]        load_w,
    input  logic                      start,
    input  logic [N_IN-1:0]           in_val,
    input  logic                      out_val,
    input  logic                      target,
    output logic                      busy,
    output logic                      done,
    output logic                      err_flag,
    output logic [N_IN*W_WIDTH-1:0]   weight,
    output logic [15:0]               miss_cnt
);

    typedef enum logic [1:0] {IDLE, UPDATE, DONE} state_t;

    localparam int IDX_W = (N_IN > 1) ? $clog2(N_IN) : 1;
    localparam logic signed [W_WIDTH:0]   LR_EXT = (W_WIDTH+1)'(LR);
    localparam logic signed [W_WIDTH-1:0] W_MAX  = {1'b0, {(W_WIDTH-1){1'b1}}};
    localparam logic signed [W_WIDTH-1:0] W_MIN  = {1'b1, {(W_WIDTH-1){1'b0}}};
    localparam logic signed [W_WIDTH-1:0] INIT_V = W_WIDTH'(INIT_W);

    state_t                    state_q, state_d;
    logic [IDX_W-1:0]          idx_q, idx_d;
    logic [N_IN-1:0]           s_in_q, s_in_d;
    logic                      neg_q, neg_d;
    logic                      err_flag_q, err_flag_d;
    logic [15:0]               miss_cnt_q, miss_cnt_d;
    logic signed [W_WIDTH-1:0] w_q [N_IN];
    logic signed [W_WIDTH-1:0] w_d [N_IN];

    // One extra bit of headroom; a sign/carry disagreement means the sum left the range.
    function automatic logic signed [W_WIDTH-1:0] sat_add(
        input logic signed [W_WIDTH-1:0] w,
        input logic                      neg
    );
        logic signed [W_WIDTH:0] wx;
        logic signed [W_WIDTH:0] s;
        wx = {w[W_WIDTH-1], w};
        s  = neg ? (wx - LR_EXT) : (wx + LR_EXT);
        if (s[W_WIDTH] != s[W_WIDTH-1]) begin
            return s[W_WIDTH] ? W_MIN : W_MAX;
        end
        return s[W_WIDTH-1:0];
    endfunction

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        s_in_d     = s_in_q;
        neg_d      = neg_q;
        err_flag_d = err_flag_q;
        miss_cnt_d = miss_cnt_q;
        for (int i = 0; i < N_IN; i++) begin
            w_d[i] = w_q[i];
        end

        case (state_q)
            IDLE: begin
                if (load_en) begin
                    // Indices beyond N_IN-1 simply match nothing.
                    for (int i = 0; i < N_IN; i++) begin
                        if (int'(load_idx) == i) begin
                            w_d[i] = load_w;
                        end
                    end
                end else if (start) begin
                    s_in_d     = in_val;
                    err_flag_d = (target != out_val);
                    if (target == out_val) begin
                        state_d = DONE;
                    end else begin
                        // err = target - out_val is -1 exactly when out_val is 1.
                        neg_d   = out_val;
                        idx_d   = '0;
                        state_d = UPDATE;
                        if (miss_cnt_q != 16'hFFFF) begin
                            miss_cnt_d = miss_cnt_q + 16'd1;
                        end
                    end
                end
            end
            UPDATE: begin
                for (int i = 0; i < N_IN; i++) begin
                    if (int'(idx_q) == i && s_in_q[i]) begin
                        w_d[i] = sat_add(w_q[i], neg_q);
                    end
                end
                if (int'(idx_q) == N_IN - 1) begin
                    idx_d   = '0;
                    state_d = DONE;
                end else begin
                    idx_d = idx_q + IDX_W'(1);
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            idx_q      <= '0;
            s_in_q     <= '0;
            neg_q      <= 1'b0;
            err_flag_q <= 1'b0;
            miss_cnt_q <= '0;
            for (int i = 0; i < N_IN; i++) begin
                w_q[i] <= INIT_V;
            end
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            s_in_q     <= s_in_d;
            neg_q      <= neg_d;
            err_flag_q <= err_flag_d;
            miss_cnt_q <= miss_cnt_d;
            for (int i = 0; i < N_IN; i++) begin
                w_q[i] <= w_d[i];
            end
        end
    end

    always_comb begin
        weight = '0;
        for (int i = 0; i < N_IN; i++) begin
            weight[i*W_WIDTH +: W_WIDTH] = w_q[i];
        end
    end

    assign busy     = (state_q != IDLE);
    assign done     = (state_q == DONE);
    assign err_flag = err_flag_q;
    assign miss_cnt = miss_cnt_q;

endmodule

// File: tb/tb_output_neuron_trainer.sv
// Directed bench for output_neuron_trainer: a cycle-timed expectation model is
// compared against every output each cycle, plus hand-computed literal checks.
module tb_output_neuron_trainer;

    localparam int N  = 5;
    localparam int W  = 10;
    localparam int LR = 8;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           load_en = 1'b0;
    logic [2:0]     load_idx = '0;
    logic [W-1:0]   load_w = '0;
    logic           start = 1'b0;
    logic [N-1:0]   in_val = '0;
    logic           out_val = 1'b0;
    logic           target = 1'b0;
    logic           busy, done, err_flag;
    logic [N*W-1:0] weight;
    logic [15:0]    miss_cnt;

    int exp_w [N];
    int exp_busy, exp_done, exp_err, exp_miss;
    int n_pass = 0;
    int n_total = 0;

    output_neuron_trainer #(.N_IN(N), .W_WIDTH(W), .LR(LR), .INIT_W(0)) dut (
        .clk(clk), .rst_n(rst_n), .load_en(load_en), .load_idx(load_idx),
        .load_w(load_w), .start(start), .in_val(in_val), .out_val(out_val),
        .target(target), .busy(busy), .done(done), .err_flag(err_flag),
        .weight(weight), .miss_cnt(miss_cnt)
    );

    always #5 clk = ~clk;

    function automatic int dut_w(int i);
        return int'($signed(weight[i*W +: W]));
    endfunction

    function automatic int msat(int v);
        if (v > 511) return 511;
        if (v < -512) return -512;
        return v;
    endfunction

    task automatic check(input string name, input int act, input int req);
        n_total++;
        if (act == req) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, req);
    endtask

    task automatic model_reset();
        for (int i = 0; i < N; i++) exp_w[i] = 0;
        exp_busy = 0; exp_done = 0; exp_err = 0; exp_miss = 0;
    endtask

    // Per-cycle comparison of all outputs against the model.
    initial begin
        forever begin
            @(posedge clk);
            #2;
            check("busy", int'(busy), exp_busy);
            check("done", int'(done), exp_done);
            check("err_flag", int'(err_flag), exp_err);
            check("miss_cnt", int'(miss_cnt), exp_miss);
            for (int i = 0; i < N; i++) check($sformatf("w%0d", i), dut_w(i), exp_w[i]);
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, expected finish");
        $fatal(1, "timeout");
    end

    task automatic load_one(input int idx, input int val);
        @(negedge clk);
        load_en = 1'b1; load_idx = 3'(idx); load_w = W'(val);
        @(posedge clk); #1;
        load_en = 1'b0;
        if (idx < N) exp_w[idx] = val;
    endtask

    task automatic load_set(input int a, input int b, input int c, input int d, input int e);
        load_one(0, a); load_one(1, b); load_one(2, c); load_one(3, d); load_one(4, e);
    endtask

    task automatic step(input logic [N-1:0] iv, input logic ov, input logic tg, input bit disturb);
        @(negedge clk);
        start = 1'b1; in_val = iv; out_val = ov; target = tg;
        @(posedge clk); #1;
        start = 1'b0;
        exp_busy = 1;
        exp_err = (ov != tg) ? 1 : 0;
        if (ov == tg) begin
            exp_done = 1;
            @(posedge clk); #1;
            exp_busy = 0; exp_done = 0;
        end else begin
            if (exp_miss < 65535) exp_miss++;
            for (int i = 0; i < N; i++) begin
                @(posedge clk); #1;
                if (iv[i]) exp_w[i] = msat(exp_w[i] + (ov ? -LR : LR));
                if (disturb && i == 0) begin
                    start = 1'b1; load_en = 1'b1; load_idx = 3'd0; load_w = W'(7);
                    out_val = ~ov; target = ~tg;
                end
                if (disturb && i == 3) begin
                    start = 1'b0; load_en = 1'b0;
                end
            end
            exp_done = 1;
            @(posedge clk); #1;
            exp_busy = 0; exp_done = 0;
        end
    endtask

    initial begin
        model_reset();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #3;
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);
        check("rst_err", int'(err_flag), 0);
        check("rst_miss", int'(miss_cnt), 0);
        check("rst_w3", dut_w(3), 0);

        // Loads, including an out-of-range index.
        load_set(100, -50, 0, 511, -512);
        load_one(6, 77);
        @(posedge clk); #3;
        check("ld_w0", dut_w(0), 100);
        check("ld_w1", dut_w(1), -50);
        check("ld_w3", dut_w(3), 511);
        check("ld_w4", dut_w(4), -512);
        check("ld_busy", int'(busy), 0);

        // Positive error on all inputs.
        step(5'b11111, 1'b0, 1'b1, 1'b0);
        check("p_w0", dut_w(0), 108);
        check("p_w1", dut_w(1), -42);
        check("p_w2", dut_w(2), 8);
        check("p_w3", dut_w(3), 511);
        check("p_w4", dut_w(4), -504);
        check("p_miss", int'(miss_cnt), 1);
        check("p_err", int'(err_flag), 1);

        // Negative error with sparse inputs, disturbed by start/load while busy.
        load_set(100, -50, 0, 511, -512);
        step(5'b10101, 1'b1, 1'b0, 1'b1);
        check("n_w0", dut_w(0), 92);
        check("n_w1", dut_w(1), -50);
        check("n_w2", dut_w(2), -8);
        check("n_w3", dut_w(3), 511);
        check("n_w4", dut_w(4), -512);
        check("n_miss", int'(miss_cnt), 2);

        // Correct classification.
        step(5'b11111, 1'b1, 1'b1, 1'b0);
        check("c_err", int'(err_flag), 0);
        check("c_miss", int'(miss_cnt), 2);
        check("c_w0", dut_w(0), 92);

        // start and load together in IDLE: load wins, no step.
        @(negedge clk);
        load_en = 1'b1; start = 1'b1; load_idx = 3'd2; load_w = W'(33);
        in_val = 5'b11111; out_val = 1'b0; target = 1'b1;
        @(posedge clk); #1;
        load_en = 1'b0; start = 1'b0;
        exp_w[2] = 33;
        @(posedge clk); #3;
        check("sl_busy", int'(busy), 0);
        check("sl_w2", dut_w(2), 33);
        check("sl_miss", int'(miss_cnt), 2);

        // Reset during the third UPDATE cycle.
        @(negedge clk);
        start = 1'b1; in_val = 5'b11111; out_val = 1'b0; target = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        exp_busy = 1; exp_err = 1; exp_miss++;
        for (int i = 0; i < 2; i++) begin
            @(posedge clk); #1;
            exp_w[i] = msat(exp_w[i] + LR);
        end
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        check("ab_busy", int'(busy), 0);
        check("ab_miss", int'(miss_cnt), 0);
        check("ab_w0", dut_w(0), 0);
        check("ab_w2", dut_w(2), 0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (8) @(posedge clk);

        // Miss counter saturation.
        @(negedge clk);
        force dut.miss_cnt_q = 16'hFFFE;
        #1;
        release dut.miss_cnt_q;
        exp_miss = 65534;
        step(5'b00001, 1'b0, 1'b1, 1'b0);
        check("sat_miss1", int'(miss_cnt), 65535);
        step(5'b00001, 1'b0, 1'b1, 1'b0);
        check("sat_miss2", int'(miss_cnt), 65535);
        check("sat_w0", dut_w(0), 16);

        repeat (2) @(posedge clk);
        #3;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
